fp_add_seq_ctrl: RTL and testbench
==================================

Name: fp_add_seq_ctrl

Overview:
- Iterative sequencer for one IEEE-754 single-precision add.
- Unpacks both operands to the 37-bit internal format and orders them (larger exponent first; denormal operand always second, as the mixed-case comparator does).
- Steps alignment, add/subtract and normalisation one bit per cycle, then repacks.
- Sits between the operand-issue logic and the result writeback, with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width.
- INT_W, 37, internal word width: sign[36], exp[35:28], mantissa[27:0].
  - Mantissa fields: carry[27], hidden[26], fraction[25:3], guard/round/sticky[2:0].
- ALIGN_MAX, 28, exponent difference at or above which the smaller operand collapses to sticky.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block idle and able to accept.
- in_a  in  32  IEEE-754 operand A.
- in_b  in  32  IEEE-754 operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  32  IEEE-754 result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1; out_valid=0; out_sum=0; busy=0; state=IDLE.
- Reset mid-operation abandons the operation and discards it; no output is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_a/in_b and go to CLASS.
- CLASS (1 cycle): unpack and order operands.
  - A zero exponent field gives hidden=0 and effective exponent 1; otherwise hidden=1.
  - Swap so that NA has the larger effective exponent. On equal exponents, NA has the larger mantissa. If exactly one operand is denormal, it is NB.
  - Compute d = expA - expB.
  - Special cases: if either exponent is 255, go straight to PACK.
    - NaN in, or +Inf + -Inf, gives 32'h7FC00000.
    - Otherwise the result is the Inf operand.
- ALIGN: one cycle per bit.
  - Each cycle: shift the NB mantissa right 1, OR the shifted-out bit into sticky, decrement d.
  - Exit when d=0.
  - If d >= ALIGN_MAX on entry, take one cycle: NB mantissa becomes sticky only.
  - d=0 skips ALIGN entirely.
- ADD (1 cycle):
  - Equal signs: add mantissas. Otherwise subtract, NA - NB.
  - Result sign is NA's sign.
  - Exact zero result gives +0 and goes to PACK.
- NORM: always at least 1 cycle.
  - If carry=1: shift right 1, exp+1, sticky preserved. One cycle only.
  - Else while hidden=0 and exp>1: shift left 1, exp-1, one per cycle.
  - hidden=0 with exp=1 is a denormal result: stored exponent 0.
  - exp reaching 255 gives ±Inf (32'h7F800000 with sign).
- PACK (1 cycle):
  - Assemble sign, exponent and fraction[25:3].
  - Rounding is truncation (round toward zero); GRS bits are discarded.
- DONE:
  - out_valid=1; out_sum is stable.
  - Stays in DONE until out_ready, then returns to IDLE (out_valid=0 next cycle).
  - in_ready=0; no new operands are accepted while DONE.
- Latency: accept edge to out_valid high is 4 + d_eff + max(1,n) cycles.
  - d_eff = d if d < ALIGN_MAX, else 1.
  - n = number of normalisation shifts.
  - Special cases: 3 cycles.
- Exactly one operation is in flight; in_valid while busy is ignored and not queued.

Decomposition:
- Shared package fp_add_pkg holds:
  - state enum IDLE, CLASS, ALIGN, ADD, NORM, PACK, DONE;
  - field position constants SIGN_BIT=36, EXP_HI=35, EXP_LO=28, CARRY_BIT=27, HIDDEN_BIT=26, FRAC_HI=25, FRAC_LO=3;
  - QNAN=32'h7FC00000;
  - POS_INF=32'h7F800000.
- One natural sub-module: fp_unpack_order.
  - Combinational; does the CLASS-state unpack and swap.
  - Generalises the existing mixed-case comparator to all three cases: normal/normal, mixed, denormal/denormal.

Test Plan:
- 3F800000 + 3F800000 -> out_sum 40000000; out_valid 5 cycles after accept (d=0, carry normalise).
- 3F800000 + BF000000 -> 3F000000; d=1, one left-shift normalise.
- 3F800000 + BF800000 -> 00000000 (+0).
- Mixed: 3F800000 + 00000001 -> 3F800000 (d>=ALIGN_MAX, sticky only, truncated); also 00000001 + 3F800000 -> same result with the swap exercised.
- Denormals: 00000001 + 00000001 -> 00000002; 00400000 + 00400000 -> 00800000 (denormal carries into normal).
- Specials and handshake:
  - 7F800000 + FF800000 -> 7FC00000.
  - Hold out_ready=0 for 10 cycles: out_sum stable, in_ready=0, in_valid pulses ignored.
  - Assert rst during ALIGN: out_valid never rises; next accepted pair computes correctly.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and field positions for the iterative single-precision adder.
// Internal word: sign[36], exp[35:28], carry[27], hidden[26], fraction[25:3], GRS[2:0].
package fp_add_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLASS,
    ALIGN,
    ADD,
    NORM,
    PACK,
    DONE
  } state_e;

  localparam int SIGN_BIT   = 36;
  localparam int EXP_HI     = 35;
  localparam int EXP_LO     = 28;
  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int FRAC_HI    = 25;
  localparam int FRAC_LO    = 3;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  // Right shift by one keeping the lost bit folded into sticky.
  function automatic logic [CARRY_BIT:0] shr_sticky(logic [CARRY_BIT:0] m);
    return {1'b0, m[CARRY_BIT:2], m[1] | m[0]};
  endfunction

endpackage

// File: rtl/fp_add_seq_ctrl_if.sv
// Operand-issue and result-writeback handshake bundle for the iterative adder.
interface fp_add_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/fp_unpack_order.sv
// Unpacks two IEEE-754 singles into the internal format and orders them so the
// larger operand is NA; a lone denormal is always NB.
module fp_unpack_order
  import fp_add_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int INT_W  = 37
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic [INT_W-1:0]      na,
  output logic                  nb_sign,
  output logic [CARRY_BIT:0]    nb_mant,
  output logic [EXP_W-1:0]      d
);

  // Denormals get effective exponent 1 and no hidden bit.
  function automatic logic [INT_W-1:0] unpack(logic [EXP_W+FRAC_W:0] x);
    logic den;
    den = (x[EXP_W+FRAC_W-1 -: EXP_W] == '0);
    return {x[EXP_W+FRAC_W], den ? EXP_W'(1) : x[EXP_W+FRAC_W-1 -: EXP_W],
            1'b0, ~den, x[FRAC_W-1:0], 3'b000};
  endfunction

  logic [INT_W-1:0] ua, ub, nbw;
  logic             a_den, b_den, swap;

  always_comb begin
    ua    = unpack(a);
    ub    = unpack(b);
    a_den = (a[EXP_W+FRAC_W-1 -: EXP_W] == '0);
    b_den = (b[EXP_W+FRAC_W-1 -: EXP_W] == '0);
    swap  = 1'b0;
    if (a_den != b_den) begin
      swap = a_den;
    end else if (ua[EXP_HI:EXP_LO] != ub[EXP_HI:EXP_LO]) begin
      swap = (ub[EXP_HI:EXP_LO] > ua[EXP_HI:EXP_LO]);
    end else begin
      swap = (ub[CARRY_BIT:0] > ua[CARRY_BIT:0]);
    end
    na      = swap ? ub : ua;
    nbw     = swap ? ua : ub;
    nb_sign = nbw[SIGN_BIT];
    nb_mant = nbw[CARRY_BIT:0];
    d       = na[EXP_HI:EXP_LO] - nbw[EXP_HI:EXP_LO];
  end

endmodule

// File: rtl/fp_add_seq_ctrl.sv
// Iterative IEEE-754 single-precision adder: one alignment or normalisation bit
// per cycle, truncating rounding, valid/ready on both sides.
module fp_add_seq_ctrl
  import fp_add_pkg::*;
#(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int INT_W     = 37,
  parameter int ALIGN_MAX = 28
) (
  input logic               clk,
  input logic               rst,
  fp_add_seq_ctrl_if.slave  bus
);

  localparam int MANT_W = CARRY_BIT + 1;

  state_e              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [INT_W-1:0]    na_q, na_d;
  logic                sb_q, sb_d;
  logic [MANT_W-1:0]   mb_q, mb_d;
  logic [EXP_W-1:0]    d_q, d_d;
  logic                flag_q, flag_d;
  logic [31:0]         res_q, res_d;
  logic [31:0]         out_sum_q, out_sum_d;
  logic                out_valid_q, out_valid_d;

  logic [INT_W-1:0]    uo_na;
  logic                uo_sb;
  logic [MANT_W-1:0]   uo_mb;
  logic [EXP_W-1:0]    uo_d;
  logic [MANT_W-1:0]   ma, sum;
  logic [EXP_W-1:0]    ea;
  logic                special;

  fp_unpack_order #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W),
    .INT_W  (INT_W)
  ) u_order (
    .a       (a_q),
    .b       (b_q),
    .na      (uo_na),
    .nb_sign (uo_sb),
    .nb_mant (uo_mb),
    .d       (uo_d)
  );

  function automatic logic [31:0] special_result(logic [31:0] a, logic [31:0] b);
    logic a_inf, b_inf, a_nan, b_nan;
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return QNAN;
    return POS_INF | {(a_inf ? a[31] : b[31]), 31'b0};
  endfunction

  // Truncating repack; a clear hidden bit here can only mean exp=1, i.e. denormal.
  function automatic logic [31:0] pack_trunc(logic [INT_W-1:0] r);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e = r[EXP_HI:EXP_LO];
    f = r[FRAC_HI:FRAC_LO];
    if (e == '1) return {r[SIGN_BIT], e, {FRAC_W{1'b0}}};
    return {r[SIGN_BIT], (r[HIDDEN_BIT] ? e : {EXP_W{1'b0}}), f};
  endfunction

  assign ma      = na_q[CARRY_BIT:0];
  assign ea      = na_q[EXP_HI:EXP_LO];
  assign sum     = (na_q[SIGN_BIT] == sb_q) ? (ma + mb_q) : (ma - mb_q);
  assign special = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    na_d        = na_q;
    sb_d        = sb_q;
    mb_d        = mb_q;
    d_d         = d_q;
    flag_d      = flag_q;
    res_d       = res_q;
    out_sum_d   = out_sum_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          flag_d  = 1'b0;
          state_d = CLASS;
        end
      end
      CLASS: begin
        na_d = uo_na;
        sb_d = uo_sb;
        mb_d = uo_mb;
        d_d  = uo_d;
        if (special) begin
          res_d   = special_result(a_q, b_q);
          flag_d  = 1'b1;
          state_d = PACK;
        end else begin
          state_d = (uo_d == '0) ? ADD : ALIGN;
        end
      end
      ALIGN: begin
        // Far-apart operands collapse in a single step to a lone sticky bit.
        if (d_q >= EXP_W'(ALIGN_MAX)) begin
          mb_d    = {{(MANT_W-1){1'b0}}, |mb_q};
          d_d     = '0;
          state_d = ADD;
        end else begin
          mb_d = shr_sticky(mb_q);
          d_d  = d_q - 1'b1;
          if (d_q == EXP_W'(1)) state_d = ADD;
        end
      end
      ADD: begin
        na_d[CARRY_BIT:0] = sum;
        if (sum == '0) begin
          flag_d  = 1'b1;
          res_d   = '0;
          state_d = PACK;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (ma[CARRY_BIT]) begin
          na_d[CARRY_BIT:0]     = shr_sticky(ma);
          na_d[EXP_HI:EXP_LO]   = ea + 1'b1;
          state_d               = PACK;
        end else if (!ma[HIDDEN_BIT] && (ea > EXP_W'(1))) begin
          // Leave on the shift that lands the hidden bit or reaches exp=1.
          na_d[CARRY_BIT:0]     = {ma[MANT_W-2:0], 1'b0};
          na_d[EXP_HI:EXP_LO]   = ea - 1'b1;
          if (ma[HIDDEN_BIT-1] || (ea == EXP_W'(2))) state_d = PACK;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        out_sum_d = flag_q ? res_q : pack_trunc(na_q);
        state_d   = DONE;
      end
      DONE: begin
        // out_valid rises one cycle into DONE and drops on the accepting edge.
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      flag_q      <= flag_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    na_q  <= na_d;
    sb_q  <= sb_d;
    mb_q  <= mb_d;
    d_q   <= d_d;
    res_q <= res_d;
  end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Scoreboard bench for fp_add_seq_ctrl: vector table with expected sums and
// latencies, output backpressure and mid-operation reset.
module tb_fp_add_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] sb_q [$];

  fp_add_seq_ctrl_if bus ();

  fp_add_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int NV = 14;
  localparam logic [31:0] VA [NV] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                     32'h00000001, 32'h00000001, 32'h00400000, 32'h7F800000,
                                     32'h40400000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800001,
                                     32'hFF800000, 32'hBF800000};
  localparam logic [31:0] VB [NV] = '{32'h3F800000, 32'hBF000000, 32'hBF800000, 32'h00000001,
                                     32'h3F800000, 32'h00000001, 32'h00400000, 32'hFF800000,
                                     32'h3F800000, 32'hBF7FFFFF, 32'h7F7FFFFF, 32'h3F800000,
                                     32'h3F800000, 32'hBF800000};
  localparam logic [31:0] VS [NV] = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h3F800000,
                                     32'h3F800000, 32'h00000002, 32'h00800000, 32'h7FC00000,
                                     32'h40800000, 32'h33800000, 32'h7F800000, 32'h7FC00000,
                                     32'hFF800000, 32'hC0000000};
  // Zero means the latency of that vector is not checked.
  localparam int          VL [NV] = '{5, 6, 0, 6, 6, 5, 5, 3, 6, 29, 5, 3, 3, 5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int cnt;
    cnt = 0;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < 200);
  endtask

  task automatic retire(input string tag);
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_underflow"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " sum"}, bus.out_sum, e);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, " out_valid_clear"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " busy_clear"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input int lat);
    int    cyc;
    string tag;
    tag = $sformatf("%h+%h", a, b);
    accept(a, b);
    sb_q.push_back(s);
    wait_valid(cyc);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    if (lat != 0) chk({tag, " latency"}, 32'(cyc), 32'(lat));
    retire(tag);
  endtask

  initial begin
    int   cyc;
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_sum", bus.out_sum, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_op(VA[i], VB[i], VS[i], VL[i]);

    // Backpressure: result held while in_valid pulses are ignored.
    accept(32'h3F800000, 32'h40000000);
    sb_q.push_back(32'h40400000);
    wait_valid(cyc);
    chk("hold latency", 32'(cyc), 32'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_valid = (i % 2 == 0);
      #1;
      chk("hold out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold out_sum", bus.out_sum, sb_q[0]);
      chk("hold in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    retire("hold");
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.out_valid | bus.busy;
    end
    chk("no queued op after hold", 32'(seen), 32'd0);

    // Reset in the middle of a long alignment.
    accept(32'h3F800000, 32'h32800000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy in align", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busy after abort", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    chk("no output after abort", 32'(seen), 32'd0);
    run_op(32'h3F800000, 32'h32800000, 32'h3F800000, 31);
    run_op(32'h3F800000, 32'h3F000000, 32'h3FC00000, 6);

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
